multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Sequencer for the multicycle variant of the MIPS processor.
- Replaces the single-cycle combinational Control unit. It steps each instruction through fetch/decode/execute/memory/writeback states over one shared ALU and one unified memory.
- It drives every datapath select and enable: PC, IR, memory, register file and ALU operand muxes.
- ALUOp feeds the existing ALUControl unchanged.

Parameters:
- OP_W, 6, opcode width.
- ALUOP_W, 4, width of ALUOp to ALUControl.
- STATE_W, 4, state register width (12 states used).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- OP  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory handshake: access completes in the cycle it is high
- PCWrite  out  1  unconditional PC load
- PCWriteCondEQ  out  1  PC load if ALU Zero=1 (beq)
- PCWriteCondNE  out  1  PC load if ALU Zero=0 (bne)
- IorD  out  1  memory address mux: 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  write-back mux: 0=ALUOut, 1=MDR
- RegDst  out  1  destination register: 0=rt, 1=rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A input: 0=PC, 1=register A
- ALUSrcB  out  2  ALU B input: 0=register B, 1=const 4, 2=SignExt, 3=SignExt<<2
- PCSource  out  2  next-PC mux: 0=ALU result, 1=ALUOut, 2=jump target
- ALUOp  out  4  operation class to ALUControl
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_op  out  1  sticky flag: unknown opcode seen; cleared only by reset

Behaviour:
- Reset: async; state<=INIT and illegal_op<=0. INIT drives all outputs 0 and ALUOp=ALUOP_ADD. INIT->FETCH unconditionally on the next clock.
- Outputs are Moore-decoded from state. Exception: in FETCH, IRWrite and PCWrite equal mem_ready (Mealy gating).
- Unlisted outputs are 0 in every state.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0. Stay while mem_ready=0; ->DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=ADD (branch target into ALUOut). Next state by OP:
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x00 -> EXEC_R
  - 0x08 (addi), 0x0C (andi), 0x0D (ori), 0x0F (lui) -> EXEC_I
  - 0x04 or 0x05 -> BRANCH
  - 0x02 -> JUMP
  - anything else: set illegal_op, retire=1, ->FETCH
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=ADD. OP=0x23 -> MEM_RD; OP=0x2B -> MEM_WR.
- MEM_RD: MemRead=1, IorD=1. Wait on mem_ready; ->MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, retire=1; ->FETCH.
- MEM_WR: MemWrite=1, IorD=1. Wait on mem_ready; when mem_ready=1, retire=1 and ->FETCH. MemWrite stays high across all wait cycles.
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=RTYPE; ->ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUOp per opcode (ADDI/ANDI/ORI/LUI); ->ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0, RegDst=1 if the instruction is R-type, else 0; retire=1; ->FETCH.
  - OP is held stable by IR through ALU_WB.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCSource=1. PCWriteCondEQ=(OP==0x04); PCWriteCondNE=(OP==0x05). retire=1; ->FETCH.
- JUMP: PCWrite=1, PCSource=2, retire=1; ->FETCH.
- Cycle counts with mem_ready held high:
  - lw: 5
  - sw: 4
  - R-type / I-type ALU: 4
  - beq/bne: 3
  - j: 3
  - Each mem_ready=0 cycle adds one cycle.
- Reset asserted mid-instruction: immediate return to INIT; no strobe survives the reset edge.
- Illegal state encodings recover to INIT.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings (INIT=0 … JUMP=11)
  - opcode constants: OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J
  - ALUOp constants: ADD=4'h0, SUB=4'h1, ADDI=4'h2, ANDI=4'h3, ORI=4'h4, LUI=4'h5, RTYPE=4'h7. ALUControl imports the same package.
- One natural sub-module: mcfsm_output_decode, a combinational state+OP to control-word decoder. The top holds the state register, next-state logic and the illegal_op flop.

Test Plan:
- Reset held 3 cycles then released -> all outputs 0 during reset; FETCH on cycle 2 with MemRead=1, ALUSrcB=1.
- OP=0x23, mem_ready=1 -> state sequence FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; RegWrite=1, MemtoReg=1 only in MEM_WB; retire pulses once in cycle 5.
- OP=0x2B, mem_ready low 2 cycles in MEM_WR -> MemWrite high for 3 consecutive cycles; retire only in the last; instruction takes 6 cycles.
- OP=0x05 -> BRANCH with PCWriteCondNE=1, PCWriteCondEQ=0, ALUOp=4'h1, PCSource=1; 3 cycles total.
- OP=0x3F -> illegal_op rises after DECODE and stays 1 through a following OP=0x00 instruction; the R-type instruction then completes in 4 cycles with RegDst=1 in ALU_WB.
- Reset pulsed during MEM_RD -> MemRead drops asynchronously; INIT, then FETCH; illegal_op=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM and the ALUControl unit.
package mips_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        StInit    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAddr = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StExecR   = 4'd7,
        StExecI   = 4'd8,
        StAluWb   = 4'd9,
        StBranch  = 4'd10,
        StJump    = 4'd11
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 4'h0;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 4'h1;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDI  = 4'h2;
    localparam logic [ALUOP_W-1:0] ALUOP_ANDI  = 4'h3;
    localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 4'h4;
    localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 4'h5;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 4'h7;

    typedef struct packed {
        logic               pc_write;
        logic               pc_write_cond_eq;
        logic               pc_write_cond_ne;
        logic               iord;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               mem_to_reg;
        logic               reg_dst;
        logic               reg_write;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [1:0]         pc_source;
        logic [ALUOP_W-1:0] alu_op;
        logic               retire;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
            OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic [ALUOP_W-1:0] imm_alu_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ANDI: return ALUOP_ANDI;
            OP_ORI:  return ALUOP_ORI;
            OP_LUI:  return ALUOP_LUI;
            default: return ALUOP_ADDI;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath (slave).
interface multicycle_control_fsm_if;
    import mips_ctrl_pkg::*;

    logic [OP_W-1:0]    OP;
    logic               mem_ready;
    logic               PCWrite;
    logic               PCWriteCondEQ;
    logic               PCWriteCondNE;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         PCSource;
    logic [ALUOP_W-1:0] ALUOp;
    logic               retire;
    logic               illegal_op;

    modport master (
        input  OP, mem_ready,
        output PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, retire,
               illegal_op
    );

    modport slave (
        output OP, mem_ready,
        input  PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, retire,
               illegal_op
    );

endinterface

// File: rtl/mcfsm_output_decode.sv
// Combinational state+opcode to control-word decoder. Moore except for the
// mem_ready-gated strobes that complete a memory access in the same cycle.
module mcfsm_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_e          i_state,
    input  logic [OP_W-1:0] i_op,
    input  logic            i_mem_ready,
    output ctrl_t           o_ctrl
);

    always_comb begin
        o_ctrl        = '0;
        o_ctrl.alu_op = ALUOP_ADD;
        case (i_state)
            StFetch: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = 2'd1;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            StDecode: begin
                o_ctrl.alu_src_b = 2'd3;
                o_ctrl.retire    = ~op_is_legal(i_op);
            end
            StMemAddr: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'd2;
            end
            StMemRd: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            StMemWb: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.retire     = 1'b1;
            end
            StMemWr: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
                o_ctrl.retire    = i_mem_ready;
            end
            StExecR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_RTYPE;
            end
            StExecI: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'd2;
                o_ctrl.alu_op    = imm_alu_op(i_op);
            end
            StAluWb: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = (i_op == OP_RTYPE);
                o_ctrl.retire    = 1'b1;
            end
            StBranch: begin
                o_ctrl.alu_src_a        = 1'b1;
                o_ctrl.alu_op           = ALUOP_SUB;
                o_ctrl.pc_source        = 2'd1;
                o_ctrl.pc_write_cond_eq = (i_op == OP_BEQ);
                o_ctrl.pc_write_cond_ne = (i_op == OP_BNE);
                o_ctrl.retire           = 1'b1;
            end
            StJump: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = 2'd2;
                o_ctrl.retire    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS sequencer: state register, next-state logic and the sticky
// illegal-opcode flag; control outputs come from mcfsm_output_decode.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
(
    input logic                      clk,
    input logic                      reset,
    multicycle_control_fsm_if.master ctrl_if
);

    state_e r_state;
    logic   r_illegal_op;
    ctrl_t  w_ctrl;

    mcfsm_output_decode u_decode (
        .i_state     (r_state),
        .i_op        (ctrl_if.OP),
        .i_mem_ready (ctrl_if.mem_ready),
        .o_ctrl      (w_ctrl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StInit;
            r_illegal_op <= 1'b0;
        end else begin
            case (r_state)
                StInit:  r_state <= StFetch;
                StFetch: if (ctrl_if.mem_ready) r_state <= StDecode;
                StDecode: begin
                    case (ctrl_if.OP)
                        OP_LW, OP_SW:                     r_state <= StMemAddr;
                        OP_RTYPE:                         r_state <= StExecR;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: r_state <= StExecI;
                        OP_BEQ, OP_BNE:                   r_state <= StBranch;
                        OP_J:                             r_state <= StJump;
                        default: begin
                            r_illegal_op <= 1'b1;
                            r_state      <= StFetch;
                        end
                    endcase
                end
                StMemAddr: r_state <= (ctrl_if.OP == OP_LW) ? StMemRd : StMemWr;
                StMemRd:   if (ctrl_if.mem_ready) r_state <= StMemWb;
                StMemWb:   r_state <= StFetch;
                StMemWr:   if (ctrl_if.mem_ready) r_state <= StFetch;
                StExecR:   r_state <= StAluWb;
                StExecI:   r_state <= StAluWb;
                StAluWb:   r_state <= StFetch;
                StBranch:  r_state <= StFetch;
                StJump:    r_state <= StFetch;
                // Unused encodings fall back to a clean restart.
                default:   r_state <= StInit;
            endcase
        end
    end

    assign ctrl_if.PCWrite       = w_ctrl.pc_write;
    assign ctrl_if.PCWriteCondEQ = w_ctrl.pc_write_cond_eq;
    assign ctrl_if.PCWriteCondNE = w_ctrl.pc_write_cond_ne;
    assign ctrl_if.IorD          = w_ctrl.iord;
    assign ctrl_if.MemRead       = w_ctrl.mem_read;
    assign ctrl_if.MemWrite      = w_ctrl.mem_write;
    assign ctrl_if.IRWrite       = w_ctrl.ir_write;
    assign ctrl_if.MemtoReg      = w_ctrl.mem_to_reg;
    assign ctrl_if.RegDst        = w_ctrl.reg_dst;
    assign ctrl_if.RegWrite      = w_ctrl.reg_write;
    assign ctrl_if.ALUSrcA       = w_ctrl.alu_src_a;
    assign ctrl_if.ALUSrcB       = w_ctrl.alu_src_b;
    assign ctrl_if.PCSource      = w_ctrl.pc_source;
    assign ctrl_if.ALUOp         = w_ctrl.alu_op;
    assign ctrl_if.retire        = w_ctrl.retire;
    assign ctrl_if.illegal_op    = r_illegal_op;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized instruction-stream bench for multicycle_control_fsm with a
// per-instruction timing and strobe-count reference model.
module tb_multicycle_control_fsm;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic ill_model = 1'b0;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .clk     (clk),
        .reset   (reset),
        .ctrl_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {11'd0, bus.PCWrite, bus.PCWriteCondEQ, bus.PCWriteCondNE, bus.IorD,
                bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUOp,
                bus.retire, bus.illegal_op};
    endfunction

    // Called one step after a rising edge with the FSM expected in its fetch cycle.
    // wf = fetch wait cycles, wm = data-memory wait cycles (lw/sw only).
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        bit lw = (op == 6'h23);
        bit sw = (op == 6'h2B);
        bit rt = (op == 6'h00);
        bit it = (op == 6'h08) || (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0F);
        bit br = (op == 6'h04) || (op == 6'h05);
        bit jp = (op == 6'h02);
        bit bad = !(lw || sw || rt || it || br || jp);
        int n;
        int acc0 = wf + 3;
        int n_rd = 0, n_wr = 0, n_ir = 0, n_pc = 0, n_rw = 0;
        int n_eq = 0, n_ne = 0, n_ret = 0, ret_at = -1;
        logic [3:0] exp_imm;

        if (lw)            n = wf + wm + 5;
        else if (sw)       n = wf + wm + 4;
        else if (rt || it) n = wf + 4;
        else if (br || jp) n = wf + 3;
        else               n = wf + 2;

        case (op)
            6'h0C:   exp_imm = 4'h3;
            6'h0D:   exp_imm = 4'h4;
            6'h0F:   exp_imm = 4'h5;
            default: exp_imm = 4'h2;
        endcase

        for (int i = 0; i < n; i++) begin
            bit in_acc;
            in_acc = (lw || sw) && (i >= acc0) && (i <= acc0 + wm);
            bus.OP = (i <= wf) ? 6'($urandom) : op;
            if (i < wf)       bus.mem_ready = 1'b0;
            else if (i == wf) bus.mem_ready = 1'b1;
            else if (in_acc)  bus.mem_ready = (i == acc0 + wm);
            else              bus.mem_ready = 1'($urandom);
            @(negedge clk);

            if (i == 0) begin
                check_eq("sticky_illegal", 32'(bus.illegal_op), 32'(ill_model));
                check_eq("fetch_ctrl", {bus.MemRead, bus.IorD, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp},
                         {1'b1, 1'b0, 1'b0, 2'd1, 4'h0});
            end
            if (i == wf + 1) check_eq("decode_srcb", 32'(bus.ALUSrcB), 32'd3);
            if ((lw || sw) && i == wf + 2)
                check_eq("addr_ctrl", {bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp}, {1'b1, 2'd2, 4'h0});
            if (in_acc)
                check_eq("mem_access", {bus.MemRead, bus.MemWrite, bus.IorD}, {lw, sw, 1'b1});
            if ((rt || it) && i == n - 2)
                check_eq("exec_ctrl", {bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp},
                         {1'b1, (it ? 2'd2 : 2'd0), (it ? exp_imm : 4'h7)});
            if (i == n - 1) begin
                if (lw || rt || it)
                    check_eq("wb_mux", {bus.MemtoReg, bus.RegDst}, {lw, rt});
                if (br)
                    check_eq("branch_ctrl", {bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource},
                             {1'b1, 2'd0, 4'h1, 2'd1});
                if (jp) check_eq("jump_src", 32'(bus.PCSource), 32'd2);
            end

            n_rd += int'(bus.MemRead);
            n_wr += int'(bus.MemWrite);
            n_ir += int'(bus.IRWrite);
            n_pc += int'(bus.PCWrite);
            n_rw += int'(bus.RegWrite);
            n_eq += int'(bus.PCWriteCondEQ);
            n_ne += int'(bus.PCWriteCondNE);
            n_ret += int'(bus.retire);
            if (bus.retire) ret_at = i;
            @(posedge clk);
            #1;
        end

        check_eq("retire_count", n_ret, 1);
        check_eq("retire_last", ret_at, n - 1);
        check_eq("memread_cycles", n_rd, wf + 1 + (lw ? wm + 1 : 0));
        check_eq("memwrite_cycles", n_wr, sw ? wm + 1 : 0);
        check_eq("irwrite_count", n_ir, 1);
        check_eq("pcwrite_count", n_pc, jp ? 2 : 1);
        check_eq("regwrite_count", n_rw, (lw || rt || it) ? 1 : 0);
        check_eq("cond_eq_count", n_eq, (op == 6'h04) ? 1 : 0);
        check_eq("cond_ne_count", n_ne, (op == 6'h05) ? 1 : 0);
        ill_model = ill_model | bad;
    endtask

    // Runs a lw into its read cycle with memory stalled, then resets asynchronously.
    task automatic reset_mid_read();
        bus.OP = 6'h23;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("memrd_before_reset", {bus.MemRead, bus.IorD}, 2'b11);
        #2 reset = 1'b1;
        #1 check_eq("reset_async_quiet", outs(), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        ill_model = 1'b0;
        @(negedge clk);
        check_eq("init_quiet_after_reset", outs(), 32'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] tbl [10] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08,
                                 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
        int k = $urandom_range(0, 10);
        return (k == 10) ? 6'($urandom) : tbl[k];
    endfunction

    initial begin
        reset = 1'b1;
        bus.OP = 6'h00;
        bus.mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("reset_quiet", outs(), 32'd0);
            @(posedge clk);
        end
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("init_quiet", outs(), 32'd0);
        @(posedge clk); #1;

        run_instr(6'h23, 0, 0);
        run_instr(6'h2B, 0, 2);
        run_instr(6'h05, 0, 0);
        run_instr(6'h04, 1, 0);
        run_instr(6'h3F, 0, 0);
        run_instr(6'h00, 0, 0);
        run_instr(6'h0F, 2, 0);
        run_instr(6'h02, 0, 0);

        for (int t = 0; t < 150; t++)
            run_instr(pick_op(), $urandom_range(0, 3), $urandom_range(0, 3));

        run_instr(6'h11, 0, 0);
        reset_mid_read();

        for (int t = 0; t < 50; t++)
            run_instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
